// File: rtl/mux_arb_pkg.sv
// Shared types for the 2:1 mux arbiter: output FSM states, burst lock states, select codes.
package mux_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_0    = 2'd1,
        LOCK_1    = 2'd2
    } lock_t;

    localparam logic SEL_0 = 1'b0;
    localparam logic SEL_1 = 1'b1;

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational 2-way round-robin picker; a held lock restricts the grant to one requester.
module mux_arb_rr_pick
    import mux_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  lock_t      lock,
    output logic [1:0] grant
);

    // Grant selection: locked owner only, otherwise single requester or alternate on a tie
    always_comb begin
        grant = 2'b00;
        case (lock)
            LOCK_0:    grant = {1'b0, req[0]};
            LOCK_1:    grant = {req[1], 1'b0};
            LOCK_NONE: begin
                case (req)
                    2'b01:   grant = 2'b01;
                    2'b10:   grant = 2'b10;
                    2'b11:   grant = (last_grant == SEL_1) ? 2'b01 : 2'b10;
                    default: grant = 2'b00;
                endcase
            end
            default:   grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mux_arb_2to1.sv
// Round-robin arbiter feeding a one-entry output register for a shared 2:1 data mux.
// Optional burst locking on din_x_last is enabled with `define MUX_ARB_BURST_LOCK_EN.
module mux_arb_2to1
    import mux_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int INIT_PRIO  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din_0_valid,
    input  logic [DATA_WIDTH-1:0] din_0,
    input  logic                  din_0_last,
    output logic                  din_0_ready,
    input  logic                  din_1_valid,
    input  logic [DATA_WIDTH-1:0] din_1,
    input  logic                  din_1_last,
    output logic                  din_1_ready,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_sel,
    input  logic                  dout_ready
);

    // Pointer value that makes INIT_PRIO win the first tie
    localparam logic LAST_RST = (INIT_PRIO == 0) ? SEL_1 : SEL_0;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    dout_sel_q, dout_sel_d;
    logic                    last_grant_q, last_grant_d;
    lock_t                   lock_q, lock_d;
    logic                    load_en_s;
    logic [1:0]              pick_s;
    logic [1:0]              grant_s;

    mux_arb_rr_pick u_pick (
        .req        ({din_1_valid, din_0_valid}),
        .last_grant (last_grant_q),
        .lock       (lock_q),
        .grant      (pick_s)
    );

    // Load enable, accept decision and next-state for the output register
    always_comb begin
        load_en_s    = (state_q == ST_EMPTY) || dout_ready;
        grant_s      = (load_en_s && !reset) ? pick_s : 2'b00;
        state_d      = state_q;
        dout_d       = dout_q;
        dout_sel_d   = dout_sel_q;
        last_grant_d = last_grant_q;
        if (grant_s != 2'b00) begin
            state_d      = ST_FULL;
            dout_sel_d   = grant_s[1];
            dout_d       = grant_s[1] ? din_1 : din_0;
            last_grant_d = grant_s[1];
        end else if (dout_ready) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

`ifdef MUX_ARB_BURST_LOCK_EN
    // Burst lock: a non-last beat pins the grant, a last beat releases it
    always_comb begin
        lock_d = lock_q;
        if (grant_s[0]) begin
            lock_d = din_0_last ? LOCK_NONE : LOCK_0;
        end else if (grant_s[1]) begin
            lock_d = din_1_last ? LOCK_NONE : LOCK_1;
        end else begin
            lock_d = lock_q;
        end
    end
`else
    logic unused_last_s;
    assign unused_last_s = din_0_last ^ din_1_last;

    // Without burst locking every beat is arbitrated on its own
    always_comb begin
        lock_d = LOCK_NONE;
    end
`endif

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            dout_q       <= '0;
            dout_sel_q   <= SEL_0;
            last_grant_q <= LAST_RST;
            lock_q       <= LOCK_NONE;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            dout_sel_q   <= dout_sel_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
        end
    end

    assign din_0_ready = grant_s[0];
    assign din_1_ready = grant_s[1];
    assign dout_valid  = (state_q == ST_FULL);
    assign dout        = dout_q;
    assign dout_sel    = dout_sel_q;

endmodule

// File: tb/tb_mux_arb_2to1.sv
// Self-checking bench for mux_arb_2to1: vector table plus hand sequences, beats tracked in a scoreboard queue.
module tb_mux_arb_2to1;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       din_0_valid, din_0_last, din_0_ready;
    logic [7:0] din_0;
    logic       din_1_valid, din_1_last, din_1_ready;
    logic [7:0] din_1;
    logic       dout_valid, dout_sel, dout_ready;
    logic [7:0] dout;

    always #5 clk = ~clk;

    mux_arb_2to1 #(.DATA_WIDTH(8), .INIT_PRIO(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .din_0_valid (din_0_valid),
        .din_0       (din_0),
        .din_0_last  (din_0_last),
        .din_0_ready (din_0_ready),
        .din_1_valid (din_1_valid),
        .din_1       (din_1),
        .din_1_last  (din_1_last),
        .din_1_ready (din_1_ready),
        .dout_valid  (dout_valid),
        .dout        (dout),
        .dout_sel    (dout_sel),
        .dout_ready  (dout_ready)
    );

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       rdy;
        logic       er0;
        logic       er1;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] sb_q[$];
    logic [8:0] last_out;
    vec_t       tbl[$];

    function automatic vec_t mk(logic v0, logic [7:0] d0, logic v1, logic [7:0] d1,
                                logic rdy, logic er0, logic er1);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.l0 = 1'b1;
        v.v1 = v1; v.d1 = d1; v.l1 = 1'b1;
        v.rdy = rdy; v.er0 = er0; v.er1 = er1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, check readies and the output register mid-cycle, update scoreboard
    task automatic step(input logic v0, input logic [7:0] d0, input logic l0,
                        input logic v1, input logic [7:0] d1, input logic l1,
                        input logic rdy, input logic er0, input logic er1, input string tag);
        din_0_valid = v0; din_0 = d0; din_0_last = l0;
        din_1_valid = v1; din_1 = d1; din_1_last = l1;
        dout_ready  = rdy;
        @(negedge clk);
        chk({tag, " din_0_ready"}, 9'(din_0_ready), 9'(er0));
        chk({tag, " din_1_ready"}, 9'(din_1_ready), 9'(er1));
        chk({tag, " dout_valid"}, 9'(dout_valid), 9'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            chk({tag, " dout"}, {dout_sel, dout}, sb_q[0]);
        end else begin
            chk({tag, " dout hold"}, {dout_sel, dout}, last_out);
        end
        if (rdy && sb_q.size() != 0) last_out = sb_q.pop_front();
        if (er0) sb_q.push_back({1'b0, d0});
        else if (er1) sb_q.push_back({1'b1, d1});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        din_0_valid = 1'b1; din_1_valid = 1'b1; dout_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("reset din_0_ready", 9'(din_0_ready), 9'd0);
            chk("reset din_1_ready", 9'(din_1_ready), 9'd0);
            if (i > 0) chk("reset dout_valid", 9'(dout_valid), 9'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        sb_q.delete();
        last_out = 9'd0;
    endtask

    initial begin
        din_0 = 8'h00; din_1 = 8'h00; din_0_last = 1'b1; din_1_last = 1'b1;
        // Alternation from reset, then backpressure, then single requester draining out
        tbl.push_back(mk(H, 8'h10, H, 8'h20, H, H, L));
        tbl.push_back(mk(H, 8'h11, H, 8'h21, H, L, H));
        tbl.push_back(mk(H, 8'h12, H, 8'h22, H, H, L));
        tbl.push_back(mk(H, 8'h13, H, 8'h23, H, L, H));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(H, 8'h14, H, 8'h24, L, L, L));
        tbl.push_back(mk(H, 8'h15, H, 8'h25, H, H, L));
        tbl.push_back(mk(L, 8'h00, H, 8'h30, H, L, H));
        tbl.push_back(mk(L, 8'h00, H, 8'h31, H, L, H));
        tbl.push_back(mk(L, 8'h00, H, 8'h32, H, L, H));
        tbl.push_back(mk(L, 8'h00, H, 8'h33, H, L, H));
        tbl.push_back(mk(L, 8'h00, L, 8'h00, H, L, L));
        tbl.push_back(mk(L, 8'h00, L, 8'h00, H, L, L));

        do_reset(2);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v0, tbl[i].d0, tbl[i].l0, tbl[i].v1, tbl[i].d1, tbl[i].l1,
                 tbl[i].rdy, tbl[i].er0, tbl[i].er1, $sformatf("vec%0d", i));
        end

`ifdef MUX_ARB_BURST_LOCK_EN
        // Three-beat burst from din_0 holds off din_1 even while din_0 idles
        step(H, 8'h40, L, H, 8'h50, H, H, H, L, "burst b1");
        step(L, 8'h41, L, H, 8'h51, H, H, L, L, "burst idle");
        step(H, 8'h42, L, H, 8'h52, H, H, H, L, "burst b2");
        step(H, 8'h43, H, H, 8'h53, H, H, H, L, "burst b3");
        step(H, 8'h44, H, H, 8'h54, H, H, L, H, "burst after");
`else
        // last=0 has no effect: each beat arbitrated on its own
        step(H, 8'h40, L, H, 8'h50, H, H, H, L, "nolock b1");
        step(L, 8'h41, L, H, 8'h51, H, H, L, H, "nolock idle");
        step(H, 8'h42, L, H, 8'h52, H, H, H, L, "nolock b2");
        step(H, 8'h43, H, H, 8'h53, H, H, L, H, "nolock b3");
        step(H, 8'h44, H, H, 8'h54, H, H, H, L, "nolock after");
`endif

        // Reset while FULL and stalled (lock held on din_1 when locking is built in)
        step(L, 8'h00, H, H, 8'h60, L, H, L, H, "rst6 load");
        step(H, 8'h61, H, H, 8'h62, H, L, L, L, "rst6 stall");
        do_reset(1);
        step(H, 8'h70, H, H, 8'h71, H, H, H, L, "rst6 tie");
        step(L, 8'h00, H, L, 8'h00, H, H, L, L, "rst6 drain");
        step(L, 8'h00, H, L, 8'h00, H, H, L, L, "rst6 empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
